operand_collector: RTL



---
 rtl/operand_collector_pkg.sv | 20 ++
 rtl/operand_bank.sv | 42 ++++
 rtl/operand_collector.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/operand_collector_pkg.sv
// Shared types and helpers for the operand collector and its bench.
package operand_collector_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_NUM_OPERANDS = 4;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    HOLD_EMPTY,
    HOLD_PENDING,
    HOLD_ISSUE
  } hold_state_t;

  // Bit offset of operand k inside a packed set of width-bit words.
  function automatic int operand_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/operand_bank.sv
// NUM_OPERANDS x DATA_WIDTH register array: indexed write, bulk load, bulk read, clear.
module operand_bank
  import operand_collector_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_OPERANDS = DEFAULT_NUM_OPERANDS,
  localparam int IDX_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               wr_en,
  input  logic [IDX_W-1:0]                   wr_idx,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               load_en,
  input  logic [NUM_OPERANDS*DATA_WIDTH-1:0] load_data,
  output logic [NUM_OPERANDS*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_OPERANDS];

  // Clear wins over writes so a discard or handoff never leaves a stray word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OPERANDS; k++) mem[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < NUM_OPERANDS; k++) mem[k] <= '0;
    end else if (load_en) begin
      for (int k = 0; k < NUM_OPERANDS; k++)
        mem[k] <= load_data[operand_lsb(k, DATA_WIDTH) +: DATA_WIDTH];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_OPERANDS; k++)
      rd_data[operand_lsb(k, DATA_WIDTH) +: DATA_WIDTH] = mem[k];
  end

endmodule

// File: rtl/operand_collector.sv
// Double-buffered serial-to-parallel operand gatherer with a one-cycle start pulse.
// Optional partial-set discard on idle is enabled by defining COLLECTOR_TIMEOUT_EN.
//
// state        | meaning
// HOLD_EMPTY   | hold bank free, handoff from the fill bank allowed
// HOLD_PENDING | hold bank has a set waiting for ready
// HOLD_ISSUE   | start is high this cycle, set issued
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_OPERANDS   = DEFAULT_NUM_OPERANDS,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CNT_W = $clog2(NUM_OPERANDS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              data_in,
  input  logic                               data_valid,
  output logic                               data_accept,
  input  logic                               ready,
  output logic                               start,
  output logic [NUM_OPERANDS*DATA_WIDTH-1:0] data_out,
  output logic [CNT_W-1:0]                   fill_count,
  output logic                               timeout
);

  localparam int IDX_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_OPERANDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPERANDS - 1);

  if (NUM_OPERANDS < 2 || NUM_OPERANDS > 16) begin : g_bad_num_operands
    $error("operand_collector: NUM_OPERANDS must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("operand_collector: TIMEOUT_CYCLES must be at least 1");
  end

  hold_state_t                        hold_state;
  logic                               live;
  logic                               xfer;
  logic                               last_xfer;
  logic                               handoff;
  logic                               discard;
  logic [NUM_OPERANDS*DATA_WIDTH-1:0] fill_words;
  logic [NUM_OPERANDS*DATA_WIDTH-1:0] hold_load;

  // live keeps data_accept low while in reset and for the first cycle after it.
  assign data_accept = live && (fill_count != FULL);
  assign xfer        = data_valid && data_accept;
  assign last_xfer   = xfer && (fill_count == LAST);
  assign handoff     = (hold_state == HOLD_EMPTY) && (last_xfer || (fill_count == FULL));

  // On a same-edge handoff the last word bypasses the fill bank.
  always_comb begin
    hold_load = fill_words;
    if (last_xfer)
      hold_load[operand_lsb(NUM_OPERANDS - 1, DATA_WIDTH) +: DATA_WIDTH] = data_in;
  end

  operand_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_OPERANDS(NUM_OPERANDS)
  ) u_fill_bank (
    .clk      (clk),
    .rst      (rst),
    .clr      (handoff || discard),
    .wr_en    (xfer),
    .wr_idx   (fill_count[IDX_W-1:0]),
    .wr_data  (data_in),
    .load_en  (1'b0),
    .load_data('0),
    .rd_data  (fill_words)
  );

  operand_bank #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_OPERANDS(NUM_OPERANDS)
  ) u_hold_bank (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .wr_en    (1'b0),
    .wr_idx   ('0),
    .wr_data  ('0),
    .load_en  (handoff),
    .load_data(hold_load),
    .rd_data  (data_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_state <= HOLD_EMPTY;
      start      <= 1'b0;
      live       <= 1'b0;
      fill_count <= '0;
    end else begin
      live  <= 1'b1;
      start <= 1'b0;
      case (hold_state)
        HOLD_EMPTY: begin
          // A ready consumer gets the set on the handoff edge itself.
          if (handoff) begin
            if (ready) begin
              hold_state <= HOLD_ISSUE;
              start      <= 1'b1;
            end else begin
              hold_state <= HOLD_PENDING;
            end
          end
        end
        HOLD_PENDING: begin
          if (ready) begin
            hold_state <= HOLD_ISSUE;
            start      <= 1'b1;
          end
        end
        HOLD_ISSUE: hold_state <= HOLD_EMPTY;
        default:    hold_state <= HOLD_EMPTY;
      endcase

      if (handoff || discard)
        fill_count <= '0;
      else if (xfer)
        fill_count <= fill_count + CNT_W'(1);
    end
  end

`ifdef COLLECTOR_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] idle_tmr;
  logic             idle_cycle;

  assign idle_cycle = (fill_count != '0) && (fill_count != FULL) && !xfer;
  assign discard    = idle_cycle && (idle_tmr == '0);

  // Down-counter: reloaded whenever the partial set is not sitting idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_tmr <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= discard;
      if (!idle_cycle || discard)
        idle_tmr <= TMR_LOAD;
      else
        idle_tmr <= idle_tmr - TMR_W'(1);
    end
  end
`else
  assign discard = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
